// File: rtl/number_format_pkg.sv
// number_format_pkg
// Shared definitions for the number-format sequencer:
//   - format codes emitted on fmt_out
//   - sequencer state encoding
//   - result record presented on the output handshake
//   - digit helpers for the serial BCD converter and the XS3 output
package number_format_pkg;

  localparam logic [2:0] FMT_SM  = 3'd0;
  localparam logic [2:0] FMT_C1  = 3'd1;
  localparam logic [2:0] FMT_C2  = 3'd2;
  localparam logic [2:0] FMT_BCD = 3'd3;
  localparam logic [2:0] FMT_XS3 = 3'd4;

  localparam int NUM_FMTS = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;

  typedef struct packed {
    logic       last;
    logic [2:0] fmt;
    logic [11:0] value;
  } result_t;

  // Shift-add-3 pre-shift correction for one BCD digit.
  function automatic logic [3:0] dabble_digit(input logic [3:0] d);
    return (d > 4'd4) ? d + 4'd3 : d;
  endfunction

  // Excess-3 adjust of a three-digit BCD value. A zero hundreds digit is
  // left blank so operands below 100 present as two XS3 digits (e.g. 9 ->
  // 0x03C); the tens and units digits are always offset by 3.
  function automatic logic [11:0] xs3_adjust(input logic [11:0] bcd);
    logic [11:0] r;
    r[11:8] = (bcd[11:8] == 4'd0) ? 4'd0 : bcd[11:8] + 4'd3;
    r[7:4]  = bcd[7:4] + 4'd3;
    r[3:0]  = bcd[3:0] + 4'd3;
    return r;
  endfunction

endpackage

// File: rtl/number_format_sequencer_bcd_serial.sv
// bcd_serial
// Serial binary-to-BCD converter (shift-add-3), one operand bit per cycle.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   start      load bin and begin an 8-cycle conversion
//   bin[7:0]   binary operand, sampled when start is high
//   done       one-cycle pulse; bcd is valid in the same cycle
//   bcd[11:0]  three BCD digits (hundreds, tens, units)
module bcd_serial
  import number_format_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        done,
  output logic [11:0] bcd
);

  logic [7:0]  shift_reg;
  logic [11:0] bcd_reg;
  logic [2:0]  cnt_reg;
  logic        active_reg;
  logic        done_reg;
  logic [11:0] bcd_adj;

  // Correct every digit before the shift so that a digit >= 5 carries
  // into the next digit when doubled.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_digit
      assign bcd_adj[gi*4 +: 4] = dabble_digit(bcd_reg[gi*4 +: 4]);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg  <= '0;
      bcd_reg    <= '0;
      cnt_reg    <= '0;
      active_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        shift_reg  <= bin;
        bcd_reg    <= '0;
        cnt_reg    <= '0;
        active_reg <= 1'b1;
      end else if (active_reg) begin
        // Operand MSB moves into the BCD LSB; the BCD MSB is always zero
        // for 8-bit operands so dropping it loses nothing.
        {bcd_reg, shift_reg} <= {bcd_adj[10:0], shift_reg, 1'b0};
        cnt_reg <= cnt_reg + 3'd1;
        if (cnt_reg == 3'd7) begin
          active_reg <= 1'b0;
          done_reg   <= 1'b1;
        end
      end
    end
  end

  assign done = done_reg;
  assign bcd  = bcd_reg;

endmodule

// File: rtl/number_format_sequencer.sv
// number_format_sequencer
// Accepts an 8-bit operand, sign and format mask, converts to BCD serially
// when BCD/XS3 is requested, then emits one 12-bit result per requested
// format in ascending format-code order.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready high only in IDLE)
//   n_in, sign_in       operand; n_in[6:0] magnitude for SM/C1/C2
//   fmt_mask            bit k requests format code k (0..4)
//   out_valid/out_ready result handshake
//   n_out, fmt_out      result value and its format code
//   out_last            final result for this operand
//   busy                sequencer not in IDLE
module number_format_sequencer
  import number_format_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  n_in,
  input  logic        sign_in,
  input  logic [4:0]  fmt_mask,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] n_out,
  output logic [2:0]  fmt_out,
  output logic        out_last,
  output logic        busy
);

  logic [1:0]  state_reg, state_next;
  logic [4:0]  mask_reg, mask_next;
  logic [6:0]  mag_reg, mag_next;
  logic        sign_reg, sign_next;
  logic [11:0] bcd_reg, bcd_next;
  logic        out_valid_reg, out_valid_next;
  result_t     res_reg, res_next;

  logic        bcd_start;
  logic        bcd_done;
  logic [11:0] bcd_value;

  // Operands of the shared result evaluator. Outputs are registered, so the
  // evaluator looks at whatever the result register will hold next: the raw
  // inputs on accept, the latched operand afterwards.
  logic [4:0]  sel_mask;
  logic [6:0]  sel_mag;
  logic        sel_sign;
  logic [11:0] sel_bcd;
  result_t     sel_res;

  logic [NUM_FMTS-1:0][11:0] cand;
  logic [NUM_FMTS-1:0][11:0] masked_cand;
  logic [NUM_FMTS-1:0][2:0]  masked_code;
  logic [4:0]                onehot;

  bcd_serial u_bcd_serial (
    .clk   (clk),
    .rst   (rst),
    .start (bcd_start),
    .bin   (n_in),
    .done  (bcd_done),
    .bcd   (bcd_value)
  );

  always_comb begin
    cand[FMT_SM]  = {4'b0, sel_sign, sel_mag};
    cand[FMT_C1]  = {4'b0, sel_sign, (sel_sign ? ~sel_mag : sel_mag)};
    // Carry out of bit 7 (negative zero) is dropped by the 8-bit add.
    cand[FMT_C2]  = {4'b0, (sel_sign ? (~{1'b0, sel_mag} + 8'd1) : {1'b0, sel_mag})};
    cand[FMT_BCD] = sel_bcd;
    cand[FMT_XS3] = xs3_adjust(sel_bcd);
  end

  // Isolate the lowest set mask bit; it picks the format to present.
  assign onehot = sel_mask & (~sel_mask + 5'd1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FMTS; gi++) begin : g_sel
      assign masked_cand[gi] = onehot[gi] ? cand[gi] : 12'd0;
      assign masked_code[gi] = onehot[gi] ? 3'(gi) : 3'd0;
    end
  endgenerate

  always_comb begin
    sel_res.value = '0;
    sel_res.fmt   = '0;
    for (int i = 0; i < NUM_FMTS; i++) begin
      sel_res.value = sel_res.value | masked_cand[i];
      sel_res.fmt   = sel_res.fmt | masked_code[i];
    end
    sel_res.last = (sel_mask != 5'd0) && ((sel_mask & (sel_mask - 5'd1)) == 5'd0);
  end

  always_comb begin
    state_next     = state_reg;
    mask_next      = mask_reg;
    mag_next       = mag_reg;
    sign_next      = sign_reg;
    bcd_next       = bcd_reg;
    out_valid_next = out_valid_reg;
    res_next       = res_reg;
    bcd_start      = 1'b0;
    sel_mask       = mask_reg;
    sel_mag        = mag_reg;
    sel_sign       = sign_reg;
    sel_bcd        = bcd_reg;

    case (state_reg)
      ST_IDLE: begin
        sel_mask = fmt_mask;
        sel_mag  = n_in[6:0];
        sel_sign = sign_in;
        if (in_valid) begin
          mask_next = fmt_mask;
          mag_next  = n_in[6:0];
          sign_next = sign_in;
          if (fmt_mask[FMT_BCD] || fmt_mask[FMT_XS3]) begin
            state_next = ST_CONV;
            bcd_start  = 1'b1;
          end else if (fmt_mask != 5'd0) begin
            state_next     = ST_EMIT;
            out_valid_next = 1'b1;
            res_next       = sel_res;
          end
        end
      end

      ST_CONV: begin
        sel_bcd = bcd_value;
        if (bcd_done) begin
          bcd_next       = bcd_value;
          state_next     = ST_EMIT;
          out_valid_next = 1'b1;
          res_next       = sel_res;
        end
      end

      ST_EMIT: begin
        // Evaluate the mask as it will be after the current handshake.
        sel_mask = mask_reg & (mask_reg - 5'd1);
        if (out_ready) begin
          mask_next = sel_mask;
          if (sel_mask == 5'd0) begin
            state_next     = ST_IDLE;
            out_valid_next = 1'b0;
            res_next       = '0;
          end else begin
            res_next = sel_res;
          end
        end
      end

      default: begin
        state_next     = ST_IDLE;
        out_valid_next = 1'b0;
        res_next       = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      mask_reg      <= '0;
      mag_reg       <= '0;
      sign_reg      <= 1'b0;
      bcd_reg       <= '0;
      out_valid_reg <= 1'b0;
      res_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      mask_reg      <= mask_next;
      mag_reg       <= mag_next;
      sign_reg      <= sign_next;
      bcd_reg       <= bcd_next;
      out_valid_reg <= out_valid_next;
      res_reg       <= res_next;
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);
  assign out_valid = out_valid_reg;
  assign n_out     = res_reg.value;
  assign fmt_out   = res_reg.fmt;
  assign out_last  = res_reg.last;

endmodule

// File: tb/tb_number_format_sequencer.sv
module tb_number_format_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  n_in;
  logic        sign_in;
  logic [4:0]  fmt_mask;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] n_out;
  logic [2:0]  fmt_out;
  logic        out_last;
  logic        busy;

  number_format_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .n_in      (n_in),
    .sign_in   (sign_in),
    .fmt_mask  (fmt_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .n_out     (n_out),
    .fmt_out   (fmt_out),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int fmt;
    int value;
    int last;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   ready_mode = 0;  // 0: always ready, 1: random, 2: 3-cycle stall per result

  // Reference formats from plain integer arithmetic.
  function automatic int ref_value(input int code, input int n, input int s);
    int mag;
    int h;
    int t;
    int u;
    mag = n % 128;
    h = n / 100;
    t = (n / 10) % 10;
    u = n % 10;
    case (code)
      0: return s * 128 + mag;
      1: return (s != 0) ? 128 + (127 - mag) : mag;
      2: return (s != 0) ? (256 - mag) % 256 : mag;
      3: return h * 256 + t * 16 + u;
      default: return ((h == 0) ? 0 : (h + 3) * 256) + (t + 3) * 16 + (u + 3);
    endcase
  endfunction

  task automatic push_expected(input int n, input int s, input int mask);
    int rem;
    exp_t e;
    rem = 0;
    for (int k = 0; k < 5; k++) if (mask[k]) rem++;
    for (int k = 0; k < 5; k++) begin
      if (mask[k]) begin
        rem--;
        e.fmt = k;
        e.value = ref_value(k, n, s);
        e.last = (rem == 0) ? 1 : 0;
        sb.push_back(e);
      end
    end
  endtask

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic send(input int n, input int s, input int mask);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 at %0t", $time);
      return;
    end
    n_in     = 8'(n);
    sign_in  = 1'(s);
    fmt_mask = 5'(mask);
    in_valid = 1'b1;
    @(posedge clk);
    push_expected(n, s, mask);
    $display("op    n=0x%02h sign=%0d mask=%05b", n, s, mask);
    #1 in_valid = 1'b0;
  endtask

  task automatic measure_latency(input string name, input int expected);
    int lat;
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 50) begin
      lat++;
      @(negedge clk);
    end
    check(name, lat, expected);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || busy) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("drain_timeout", (w < 2000) ? 1 : 0, 1);
  endtask

  // out_ready driver, updated just after each rising edge.
  initial begin : ready_driver
    int c;
    c = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (out_valid) begin
            if (c < 3) begin
              out_ready = 1'b0;
              c++;
            end else begin
              out_ready = 1'b1;
              c = 0;
            end
          end else begin
            out_ready = 1'b0;
            c = 0;
          end
        end
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks that a
  // stalled result holds steady.
  initial begin : monitor
    logic stalled;
    int   pv;
    int   pf;
    int   pl;
    exp_t e;
    stalled = 1'b0;
    pv = 0;
    pf = 0;
    pl = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
        continue;
      end
      if (stalled) begin
        check("hold_valid", out_valid, 1);
        check("hold_value", n_out, pv);
        check("hold_fmt", fmt_out, pf);
        check("hold_last", out_last, pl);
      end
      if (out_valid && out_ready) begin
        stalled = 1'b0;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got fmt=%0d value=0x%03h expected none", fmt_out, n_out);
        end else begin
          e = sb.pop_front();
          $display("out   fmt=%0d value=0x%03h last=%0d (exp fmt=%0d value=0x%03h last=%0d)",
                   fmt_out, n_out, out_last, e.fmt, e.value, e.last);
          check("out_fmt", fmt_out, e.fmt);
          check("out_value", n_out, e.value);
          check("out_last", out_last, e.last);
        end
      end else if (out_valid) begin
        stalled = 1'b1;
        pv = n_out;
        pf = fmt_out;
        pl = out_last;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin : stimulus
    rst      = 1'b1;
    in_valid = 1'b0;
    n_in     = '0;
    sign_in  = 1'b0;
    fmt_mask = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_n_out", n_out, 0);
    check("rst_fmt_out", fmt_out, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // SM/C1/C2 only, immediate emission.
    ready_mode = 0;
    send(8'h85, 1, 5'b00111);
    measure_latency("lat_no_bcd", 0);
    drain();

    // BCD/XS3, nine cycles of conversion latency.
    send(8'hFF, 0, 5'b11000);
    measure_latency("lat_bcd", 9);
    drain();

    // All formats with stalls on every result.
    ready_mode = 2;
    send(8'h85, 1, 5'b11111);
    drain();

    // Negative zero.
    ready_mode = 0;
    send(8'h00, 1, 5'b00111);
    drain();

    // Empty mask: dropped, no output, ready again next cycle.
    send(8'h55, 0, 5'b00000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mask0_in_ready", in_ready, 1);
      check("mask0_out_valid", out_valid, 0);
    end

    // in_valid held high with changing inputs during EMIT.
    ready_mode = 2;
    @(negedge clk);
    n_in     = 8'h12;
    sign_in  = 1'b0;
    fmt_mask = 5'b00011;
    in_valid = 1'b1;
    @(posedge clk);
    push_expected(8'h12, 0, 5'b00011);
    $display("op    n=0x12 sign=0 mask=00011 (in_valid held)");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("hold_in_ready", in_ready, 0);
      n_in     = 8'($urandom);
      sign_in  = 1'($urandom);
      fmt_mask = 5'b11111;
    end
    in_valid = 1'b0;
    drain();

    // Reset during conversion, then a fresh operand.
    ready_mode = 0;
    send(8'hFF, 0, 5'b11000);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_n_out", n_out, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    send(8'h09, 0, 5'b10000);
    drain();

    // Randomized operands, masks and back-pressure.
    for (int i = 0; i < 40; i++) begin
      ready_mode = int'($urandom_range(0, 2));
      send(int'($urandom_range(0, 255)), int'($urandom_range(0, 1)), int'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
